// File: rtl/vga_arm_overlay.sv
// VGA overlay: grid, border and a gripper-coloured arm marker; rgb trails the counters by 2 cycles.
// Position strobes land in a shadow register and go live at the frame boundary; the block never backpressures.
module vga_arm_overlay #(
  parameter int GRID_SHIFT  = 6,
  parameter int MARKER_HALF = 8,
  parameter int BLINK_BIT   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  counter_x,
  input  logic [9:0]  counter_y,
  input  logic        in_display_area,
  input  logic        vga_h_sync_in,
  input  logic        vga_v_sync_in,
  input  logic [9:0]  pos_x,
  input  logic [9:0]  pos_y,
  input  logic        gripper_closed,
  input  logic        blink_en,
  input  logic        pos_valid,
  output logic [11:0] rgb,
  output logic        vga_h_sync_out,
  output logic        vga_v_sync_out,
  output logic        frame_tick,
  output logic        pos_pending
);

  localparam logic [9:0]  X_MAX   = 10'd640;
  localparam logic [9:0]  Y_MAX   = 10'd480;
  localparam logic [9:0]  BND_Y   = 10'd481;
  localparam logic [9:0]  X_HOME  = 10'd320;
  localparam logic [9:0]  Y_HOME  = 10'd240;
  localparam logic [10:0] HALF    = 11'(MARKER_HALF);

  localparam logic [11:0] C_BLACK  = 12'h000;
  localparam logic [11:0] C_RED    = 12'hF00;
  localparam logic [11:0] C_GREEN  = 12'h0F0;
  localparam logic [11:0] C_BORDER = 12'hFFF;
  localparam logic [11:0] C_GRID   = 12'h444;
  localparam logic [11:0] C_BACK   = 12'h008;

  logic [9:0]  sh_x, sh_y, act_x, act_y;
  logic        sh_g, act_g;
  logic [7:0]  frame_cnt;
  logic [9:0]  clamp_x, clamp_y;
  logic        boundary;

  logic        s1_marker, s1_grid, s1_border, s1_blink_off;
  logic        hit_x, hit_y;
  logic [10:0] cx_w, cy_w, ax_w, ay_w;
  logic [11:0] pix_next;

  assign clamp_x  = (pos_x > X_MAX) ? X_MAX : pos_x;
  assign clamp_y  = (pos_y > Y_MAX) ? Y_MAX : pos_y;
  assign boundary = (counter_x == 10'd0) && (counter_y == BND_Y);

  // Position double-buffer; a strobe on the boundary cycle goes live immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_x        <= X_HOME;
      sh_y        <= Y_HOME;
      sh_g        <= 1'b0;
      act_x       <= X_HOME;
      act_y       <= Y_HOME;
      act_g       <= 1'b0;
      pos_pending <= 1'b0;
      frame_cnt   <= 8'd0;
      frame_tick  <= 1'b0;
    end else begin
      frame_tick <= boundary;
      if (boundary) begin
        frame_cnt   <= frame_cnt + 8'd1;
        pos_pending <= 1'b0;
        if (pos_valid) begin
          sh_x  <= clamp_x;
          sh_y  <= clamp_y;
          sh_g  <= gripper_closed;
          act_x <= clamp_x;
          act_y <= clamp_y;
          act_g <= gripper_closed;
        end else begin
          act_x <= sh_x;
          act_y <= sh_y;
          act_g <= sh_g;
        end
      end else if (pos_valid) begin
        sh_x        <= clamp_x;
        sh_y        <= clamp_y;
        sh_g        <= gripper_closed;
        pos_pending <= 1'b1;
      end
    end
  end

  // 11-bit compares so the window neither underflows at 0 nor wraps near 1023.
  assign cx_w  = {1'b0, counter_x};
  assign cy_w  = {1'b0, counter_y};
  assign ax_w  = {1'b0, act_x};
  assign ay_w  = {1'b0, act_y};
  assign hit_x = (cx_w + HALF >= ax_w) && (cx_w <= ax_w + HALF);
  assign hit_y = (cy_w + HALF >= ay_w) && (cy_w <= ay_w + HALF);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_marker    <= 1'b0;
      s1_grid      <= 1'b0;
      s1_border    <= 1'b0;
      s1_blink_off <= 1'b0;
    end else begin
      s1_marker    <= hit_x && hit_y;
      s1_grid      <= (counter_x[GRID_SHIFT-1:0] == '0) || (counter_y[GRID_SHIFT-1:0] == '0);
      s1_border    <= (counter_x == 10'd0) || (counter_x == X_MAX) ||
                      (counter_y == 10'd0) || (counter_y == Y_MAX);
      s1_blink_off <= blink_en && frame_cnt[BLINK_BIT];
    end
  end

  always_comb begin
    pix_next = C_BACK;
    if (!in_display_area) begin
      pix_next = C_BLACK;
    end else if (s1_marker && !s1_blink_off) begin
      pix_next = act_g ? C_RED : C_GREEN;
    end else if (s1_border) begin
      pix_next = C_BORDER;
    end else if (s1_grid) begin
      pix_next = C_GRID;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb            <= C_BLACK;
      vga_h_sync_out <= 1'b0;
      vga_v_sync_out <= 1'b0;
    end else begin
      rgb            <= pix_next;
      vga_h_sync_out <= vga_h_sync_in;
      vga_v_sync_out <= vga_v_sync_in;
    end
  end

endmodule

// File: doc/vga_arm_overlay.md
# vga_arm_overlay

Pixel stage directly downstream of the VGA sync/counter generator. Consumes `counter_x`/`counter_y`, `in_display_area` and the registered syncs, and produces registered 12-bit RGB plus re-aligned syncs. The picture is a reference grid with a marker showing the robot-arm target position, coloured by gripper state. Position updates come from the arm controller and take effect only at a frame boundary, so the display never tears.

## Interface
- `GRID_SHIFT`, 6: grid pitch is 2^GRID_SHIFT px.
- `MARKER_HALF`, 8: marker half-size; the square is 2·MARKER_HALF+1 px per side.
- `BLINK_BIT`, 4: frame-counter bit that gates blinking.
- `clk` in 1: pixel clock, the same clock as the sync generator.
- `rst_n` in 1: synchronous, active-low reset.
- `counter_x` in 10: horizontal count, 0–800.
- `counter_y` in 10: vertical count, 0–525.
- `in_display_area` in 1: visible flag for x≤640, y≤480; registered, so it lags the counters by 1 cycle.
- `vga_h_sync_in`, `vga_v_sync_in` in 1 each: registered syncs; they lag the counters by 1 cycle.
- `pos_x` in 10, `pos_y` in 10: new target position.
- `gripper_closed` in 1: gripper state, sampled with the position.
- `blink_en` in 1: arm moving; the marker blinks.
- `pos_valid` in 1: one-cycle strobe that loads `pos_x`, `pos_y` and `gripper_closed`.
- `rgb` out 12: {R[3:0],G[3:0],B[3:0]}.
- `vga_h_sync_out`, `vga_v_sync_out` out 1 each: syncs aligned to `rgb`.
- `frame_tick` out 1: one-cycle pulse at each frame boundary.
- `pos_pending` out 1: the shadow register holds a value not yet displayed.

## Operation
- **Shadow registers** `sh_x`, `sh_y`, `sh_g`:
  - Load on `pos_valid`.
  - `pos_x`>640 clamps to 640; `pos_y`>480 clamps to 480.
  - Loading sets `pos_pending`.
- **Frame boundary**: the cycle with `counter_x`==0 && `counter_y`==481.
  - Active registers `act_x`, `act_y`, `act_g` ← shadow.
  - `pos_pending` ← 0.
  - `frame_cnt` (8-bit, wraps 255→0) increments.
  - `frame_tick` registers high for 1 cycle.
- **`pos_valid` on the boundary cycle**: the clamped input bypasses the shadow and goes straight into both shadow and active; `pos_pending` ends at 0.
- **Stage 1** (registered from the counters):
  - Marker hit: `cx`+MARKER_HALF ≥ `act_x` && `cx` ≤ `act_x`+MARKER_HALF, and the same test for y.
  - All sums are computed in 11-bit unsigned, so there is no underflow at the left/top edge and no wrap at the right edge.
  - Grid hit: `cx[GRID_SHIFT-1:0]`==0 || `cy[GRID_SHIFT-1:0]`==0.
  - Border hit: `cx`==0 || `cx`==640 || `cy`==0 || `cy`==480.
  - Blink-off = `blink_en` && `frame_cnt[BLINK_BIT]`.
- **Stage 2** (registered), using stage-1 flags and `in_display_area` from the same cycle. Colour priority:
  1. Not in display → 0x000.
  2. Marker && !blink-off → 0xF00 if `act_g`, else 0x0F0.
  3. Border → 0xFFF.
  4. Grid → 0x444.
  5. Otherwise → 0x008.
- **Sync outputs**: `vga_h_sync_out`/`vga_v_sync_out` are the inputs registered once.
- **Reset** (`rst_n`=0 at a clk edge):
  - `rgb`=0, both sync outs 0, `frame_tick`=0, `pos_pending`=0, `frame_cnt`=0.
  - Shadow and active position = (320,240), gripper = 0.
  - All stage-1 flags = 0.
  - Reset mid-frame discards any pending position; output restarts black until valid pipeline data arrives.

## Timing
- `rgb` for counter value (x,y) appears 2 cycles after the counters show (x,y), and 1 cycle after `in_display_area` for that pixel.
- Sync outputs trail the sync inputs by exactly 1 cycle, keeping them aligned with `rgb`.
- `frame_tick` is high in the cycle after the boundary cycle.
- Active registers change on the boundary edge. The first pixel drawn with the new position is (0,0) of the next frame.
- A `pos_valid` at any cycle other than the boundary shows on the next boundary. `pos_pending` rises the cycle after the strobe.
- Back-to-back `pos_valid` strobes: the last one wins. There is no backpressure and the block is always ready.
- Blink period: the marker toggles every 2^BLINK_BIT frames.

## Test plan
- **Reset**: hold `rst_n`=0 for 3 cycles, then release → `rgb`=0, `pos_pending`=0, `frame_tick`=0. The first frame draws the marker centred at (320,240) in green (0x0F0).
- **Deferred update**: `pos_valid` with (100,50), `gripper_closed`=1 at y=200 → `pos_pending`=1.
  - Pixel (100,50) stays 0x008 or grid colour in the current frame.
  - In the next frame, pixels (92..108, 42..58) read 0xF00; `pos_pending` clears at the boundary.
- **Edge clamp**: position (3,700) → y clamps to 480. Marker covers x 0..11, y 472..480, with no wrap pixels at x≈1020. The border at x=0 is overridden by the marker.
- **Boundary collision**: `pos_valid` with (400,300) exactly at x=0, y=481 → active updates on that edge, `pos_pending`=0, `frame_tick` pulses the next cycle.
- **Alignment and blink**:
  - Sync outs equal sync ins delayed by 1 cycle.
  - Pixel (64,10) = 0x444 and (640,10) = 0xFFF, each 2 cycles after the counters.
  - With `blink_en`=1, the marker is absent for frames with `frame_cnt` 16–31 and present for frames 0–15.
